// File: rtl/mul_pkg.sv
// Shared types and constants for the multiplier issue stage.
//   state_e  : dispatch FSM states
//   entry_t  : one buffered operation {a, b, tag}
package mul_pkg;

    // Latency of the iterative 32x32 multiplier this block feeds.
    localparam int MUL_LATENCY = 32;

    // Width of the tag field carried in a FIFO entry. The dispatcher's TAG_W
    // parameter is expected to match this.
    localparam int ENTRY_TAG_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_e;

    typedef struct packed {
        logic [31:0]            a;
        logic [31:0]            b;
        logic [ENTRY_TAG_W-1:0] tag;
    } entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, in-order, no bypass (an entry written this cycle is
// readable from the next cycle on).
//   clk, rst_n   : clock, async active-low reset (empties the FIFO)
//   push, wdata  : write request and data (ignored while full)
//   pop          : read request (ignored while empty)
//   rdata        : current head entry
//   full, empty  : occupancy flags from registered pointers
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mul_dispatch.sv
// Issue stage for the 32x32 iterative multiplier. Buffers operand pairs,
// issues one at a time with a single-cycle start pulse, waits for the
// product or a timeout, and returns the tagged result on a ready/valid port.
//   in_valid/in_ready/in_a/in_b       : operand stream
//   mul_valid_in/mul_a/mul_b          : start pulse and operands to multiplier
//   mul_valid_out/mul_r               : product from multiplier
//   out_valid/out_ready/out_r/out_tag : result stream
//   out_err                           : result timed out (out_r = 0)
//   busy                              : work pending or in flight
//
// state | meaning
// IDLE  | nothing in flight, waiting for a FIFO entry
// ISSUE | start pulse driven, head entry popped
// WAIT  | multiplier running, counting toward the timeout
// HOLD  | result presented, waiting for out_ready
module mul_dispatch
    import mul_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TAG_W       = ENTRY_TAG_W,
    parameter int MUL_TIMEOUT = MUL_LATENCY + 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic             mul_valid_in,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic             mul_valid_out,
    input  logic [63:0]      mul_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_r,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic             busy
);
    localparam int CW = $clog2(MUL_TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [TAG_W-1:0] tag_cnt_q, tag_cnt_d;
    logic [CW-1:0]    wait_cnt_q, wait_cnt_d;
    logic             mul_valid_in_q, mul_valid_in_d;
    logic [31:0]      mul_a_q, mul_a_d;
    logic [31:0]      mul_b_q, mul_b_d;
    logic             out_valid_q, out_valid_d;
    logic [63:0]      out_r_q, out_r_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_err_q, out_err_d;

    entry_t push_entry, head;
    logic   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic   res_hit, tmo_hit;

    // Held low during reset so nothing is accepted before the FIFO is clean.
    assign in_ready  = rst_n && !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign fifo_pop  = (state_q == ISSUE);

    assign push_entry.a   = in_a;
    assign push_entry.b   = in_b;
    assign push_entry.tag = ENTRY_TAG_W'(tag_cnt_q);

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (push_entry),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The first WAIT cycle ignores mul_valid_out; a result on the timeout
    // cycle still wins over the error.
    assign res_hit = (state_q == WAIT) && mul_valid_out && (wait_cnt_q != '0);
    assign tmo_hit = (state_q == WAIT) && (wait_cnt_q == CW'(MUL_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!fifo_empty) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (res_hit || tmo_hit) state_d = HOLD;
            HOLD:    if (out_ready) state_d = fifo_empty ? IDLE : ISSUE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tag_cnt_d      = fifo_push ? tag_cnt_q + TAG_W'(1) : tag_cnt_q;
        wait_cnt_d     = (state_q == WAIT) ? wait_cnt_q + CW'(1) : '0;
        mul_valid_in_d = (state_d == ISSUE);
        mul_a_d        = mul_a_q;
        mul_b_d        = mul_b_q;
        out_tag_d      = out_tag_q;
        out_valid_d    = (state_d == HOLD);
        out_r_d        = out_r_q;
        out_err_d      = out_err_q;
        // Operands are loaded one cycle early so they line up with the pulse.
        if (state_d == ISSUE) begin
            mul_a_d   = head.a;
            mul_b_d   = head.b;
            out_tag_d = TAG_W'(head.tag);
        end
        if (res_hit) begin
            out_r_d   = mul_r;
            out_err_d = 1'b0;
        end else if (tmo_hit) begin
            out_r_d   = '0;
            out_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_cnt_q      <= '0;
            wait_cnt_q     <= '0;
            mul_valid_in_q <= 1'b0;
            mul_a_q        <= '0;
            mul_b_q        <= '0;
            out_valid_q    <= 1'b0;
            out_r_q        <= '0;
            out_tag_q      <= '0;
            out_err_q      <= 1'b0;
        end else begin
            tag_cnt_q      <= tag_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            mul_valid_in_q <= mul_valid_in_d;
            mul_a_q        <= mul_a_d;
            mul_b_q        <= mul_b_d;
            out_valid_q    <= out_valid_d;
            out_r_q        <= out_r_d;
            out_tag_q      <= out_tag_d;
            out_err_q      <= out_err_d;
        end
    end

    assign mul_valid_in = mul_valid_in_q;
    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;
    assign out_valid    = out_valid_q;
    assign out_r        = out_r_q;
    assign out_tag      = out_tag_q;
    assign out_err      = out_err_q;
    assign busy         = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mul_dispatch.sv
module tb_mul_dispatch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready;
    logic [31:0] in_a, in_b;
    logic        mul_valid_in;
    logic [31:0] mul_a, mul_b;
    logic        mul_valid_out;
    logic [63:0] mul_r;
    logic        out_valid, out_ready;
    logic [63:0] out_r;
    logic [3:0]  out_tag;
    logic        out_err, busy;

    int total = 0;
    int bad   = 0;

    mul_dispatch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .mul_valid_in (mul_valid_in),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_valid_out(mul_valid_out),
        .mul_r        (mul_r),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_r        (out_r),
        .out_tag      (out_tag),
        .out_err      (out_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: product valid m_lat cycles after the start pulse.
    int          m_lat  = 32;
    logic        m_hang = 1'b0;
    logic        m_busy = 1'b0;
    int          m_cnt  = 0;
    logic [63:0] m_res  = '0;

    always @(posedge clk) begin
        if (mul_valid_in) begin
            m_busy <= 1'b1;
            m_cnt  <= m_lat - 1;
            m_res  <= {32'b0, mul_a} * {32'b0, mul_b};
        end else if (m_busy) begin
            if (m_cnt == 0) m_busy <= 1'b0;
            else            m_cnt  <= m_cnt - 1;
        end
    end
    assign mul_valid_out = m_busy && (m_cnt == 0) && !m_hang;
    assign mul_r         = m_res;

    // Cycle and event monitors.
    int   cyc = 0, pulse_cnt = 0, last_pulse_cyc = 0, dbl_cnt = 0;
    int   ov_hi = 0, vo_cnt = 0;
    logic prev_vin = 1'b0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        prev_vin <= mul_valid_in;
        if (mul_valid_in) begin
            pulse_cnt      <= pulse_cnt + 1;
            last_pulse_cyc <= cyc;
        end
        if (prev_vin && mul_valid_in) dbl_cnt <= dbl_cnt + 1;
        if (out_valid)     ov_hi  <= ov_hi + 1;
        if (mul_valid_out) vo_cnt <= vo_cnt + 1;
    end

    int push_cyc = 0;
    int ov_cyc   = 0;

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $error("FAIL push_wait observed=in_ready_low expected=in_ready_high");
        end
        @(posedge clk);
        #1;
        push_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string nm, input logic [63:0] er,
                            input logic [3:0] et, input logic ee);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        ov_cyc = cyc;
        if (!out_valid) begin
            total++;
            bad++;
            $error("FAIL %s_timeout observed=0 expected=1", nm);
        end else begin
            chk({nm, "_r"}, out_r, er);
            chk({nm, "_tag"}, 64'(out_tag), 64'(et));
            chk({nm, "_err"}, 64'(out_err), 64'(ee));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int c0, p0, p1, v0, h0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_mul_valid_in", 64'(mul_valid_in), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_out_r", out_r, 0);
        chk("rst_out_tag", 64'(out_tag), 0);
        chk("rst_mul_a", 64'(mul_a), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 1);

        // Single op 3*5
        p0 = pulse_cnt;
        push(32'd3, 32'd5);
        c0 = push_cyc;
        wait_out("single", 64'd15, 4'd0, 1'b0);
        chk("single_issue_cyc", 64'(last_pulse_cyc - c0), 64'd1);
        chk("single_out_lat", 64'(ov_cyc - c0), 64'd34);
        chk("single_pulses", 64'(pulse_cnt - p0), 64'd1);
        chk("single_mul_a", 64'(mul_a), 64'd3);
        chk("single_mul_b", 64'(mul_b), 64'd5);

        // Max operands
        push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_out("max", 64'hFFFF_FFFE_0000_0001, 4'd1, 1'b0);

        // Full FIFO: multiplier slow on the first op
        do_reset();
        m_lat = 38;
        push(32'd2, 32'd3);
        push(32'd4, 32'd5);
        push(32'd6, 32'd7);
        push(32'd8, 32'd9);
        push(32'd10, 32'd11);
        m_lat = 32;
        @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 0);
        // A sixth offer while full must be refused.
        in_valid = 1'b1;
        in_a     = 32'd12;
        in_b     = 32'd13;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        wait_out("full0", 64'd6, 4'd0, 1'b0);
        wait_out("full1", 64'd20, 4'd1, 1'b0);
        wait_out("full2", 64'd42, 4'd2, 1'b0);
        wait_out("full3", 64'd72, 4'd3, 1'b0);
        wait_out("full4", 64'd110, 4'd4, 1'b0);
        repeat (3) @(negedge clk);
        chk("full_drained_busy", 64'(busy), 0);

        // Backpressure during HOLD
        out_ready = 1'b0;
        push(32'd7, 32'd9);
        push(32'd2, 32'd2);
        wait_out("bp0", 64'd63, 4'd5, 1'b0);
        p1 = pulse_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(out_valid), 1);
            chk("bp_r", out_r, 64'd63);
            chk("bp_tag", 64'(out_tag), 64'd5);
        end
        chk("bp_no_pulse", 64'(pulse_cnt), 64'(p1));
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_drop", 64'(out_valid), 0);
        chk("bp_next_issue", 64'(mul_valid_in), 1);
        wait_out("bp1", 64'd4, 4'd6, 1'b0);

        // Timeout, then normal recovery
        m_hang = 1'b1;
        push(32'd6, 32'd7);
        c0 = push_cyc;
        wait_out("tmo", 64'd0, 4'd7, 1'b1);
        chk("tmo_lat", 64'(ov_cyc - c0), 64'd42);
        m_hang = 1'b0;
        push(32'd100, 32'd200);
        wait_out("post_tmo", 64'd20000, 4'd8, 1'b0);

        // Tag wrap
        do_reset();
        for (int i = 0; i < 17; i++) begin
            push(32'(i + 1), 32'(1000 + i));
            wait_out($sformatf("wrap%0d", i), 64'(i + 1) * 64'(1000 + i), 4'(i % 16), 1'b0);
        end

        // Reset in the middle of WAIT; the late product must be dropped.
        p0 = pulse_cnt;
        push(32'd5, 32'd5);
        repeat (8) @(negedge clk);
        v0 = vo_cnt;
        h0 = ov_hi;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 0);
        chk("mid_rst_mul_a", 64'(mul_a), 0);
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_out_tag", 64'(out_tag), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("mid_rst_late_result_seen", 64'(vo_cnt - v0), 64'd1);
        chk("mid_rst_no_output", 64'(ov_hi - h0), 64'd0);
        chk("mid_rst_out_r", out_r, 0);
        chk("mid_rst_out_err", 64'(out_err), 0);
        chk("mid_rst_busy_after", 64'(busy), 0);
        chk("mid_rst_in_ready_after", 64'(in_ready), 1);
        chk("mid_rst_pulses", 64'(pulse_cnt - p0), 64'd1);
        chk("no_double_pulse", 64'(dbl_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mul_dispatch.md
Name: mul_dispatch

Overview:
Upstream issue stage for the 32x32 iterative multiplier. Accepts operand pairs on a ready/valid stream and buffers them in a small in-order FIFO. Issues one operation at a time to the multiplier using a single-cycle start pulse, then waits for completion or timeout. Returns each 64-bit product on a ready/valid output stream, tagged with a sequence number.

Parameters:
DEPTH, 4, operand FIFO entries (power of 2, >=2)
TAG_W, 4, width of sequence tag; wraps mod 2^TAG_W
MUL_TIMEOUT, 40, max cycles in WAIT before declaring error (> multiplier latency of 32)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO can accept
in_a  in  32  multiplicand
in_b  in  32  multiplier
mul_valid_in  out  1  start pulse to multiplier
mul_a  out  32  operand a to multiplier
mul_b  out  32  operand b to multiplier
mul_valid_out  in  1  multiplier result valid
mul_r  in  64  multiplier product
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_r  out  64  product (0 on error)
out_tag  out  TAG_W  sequence tag of the result
out_err  out  1  result timed out
busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Reset (rst_n low, async): FIFO emptied, tag counter 0, FSM to IDLE. mul_valid_in, out_valid, out_err, busy = 0; mul_a, mul_b, out_r, out_tag = 0; in_ready = 0 while rst_n low.
- Reset mid-operation: any in-flight result is discarded. The multiplier is not reset by this block. mul_valid_out is ignored outside WAIT.
- FIFO:
  - in_ready = !full (registered-state based, no comb path from out_ready).
  - Push on in_valid && in_ready; entry stores {a, b, tag}, then tag counter increments mod 2^TAG_W.
  - No bypass: an entry pushed in cycle N is poppable at cycle N+1 at the earliest.
  - A simultaneous push and pop is legal whenever in_ready = 1.
- FSM, states IDLE, ISSUE, WAIT, HOLD:
  - IDLE: if FIFO non-empty, go to ISSUE.
  - ISSUE (exactly 1 cycle):
    - mul_valid_in = 1; mul_a/mul_b = head a/b (registered outputs, valid in the same cycle as the pulse).
    - Pop head, latch its tag, clear wait counter, go to WAIT.
  - WAIT:
    - Wait counter increments each cycle. mul_valid_out is ignored in the first WAIT cycle.
    - From the second cycle on, mul_valid_out = 1 captures out_r = mul_r and out_err = 0, then goes to HOLD.
    - If the counter reaches MUL_TIMEOUT first: out_r = 0, out_err = 1, go to HOLD.
    - If both happen in the same cycle, the result wins (out_err = 0).
  - HOLD:
    - out_valid = 1; out_r, out_tag, out_err held stable until out_ready.
    - On handshake: out_valid drops next cycle. Go to ISSUE if the FIFO is non-empty, else IDLE.
- mul_a and mul_b hold the last issued values outside ISSUE. mul_valid_in is never high for two consecutive cycles. At most one operation is outstanding.
- Latency: push into an empty idle block at cycle 0 → ISSUE at cycle 2 → out_valid at issue + multiplier latency + 1.
- Results leave strictly in push order. out_tag equals the tag assigned at push.
- Width rules: out_r is the unmodified 64-bit mul_r. No truncation or sign handling (unsigned).

Decomposition:
- Package mul_pkg: state enum (IDLE, ISSUE, WAIT, HOLD), the MUL_LATENCY = 32 constant, and a packed operand-entry struct {a, b, tag}.
- One natural sub-module, sync_fifo, parameterised on width and depth, with full/empty flags and wrap-around pointers carrying an extra MSB.
- The FSM, wait counter and output registers live in mul_dispatch.

Test Plan:
- Single op: a=3, b=5 with a behavioural multiplier model (32-cycle latency) → exactly one mul_valid_in pulse, mul_a=3, mul_b=5, then out_valid with out_r=15, out_tag=0, out_err=0.
- Max operands: a=b=0xFFFFFFFF → out_r=0xFFFFFFFE00000001.
- Full FIFO:
  - Stimulus: 5 back-to-back pushes with out_ready=1 and the multiplier stalled on the first op.
  - Response: in_ready=0 once 4 entries are held; results emerge in order with tags 0..4 and correct products.
- Backpressure: out_ready=0 for 10 cycles during HOLD → out_valid, out_r and out_tag stable; no new mul_valid_in pulse until the handshake.
- Timeout and tag wrap:
  - Timeout: the model never asserts mul_valid_out → after 40 WAIT cycles out_valid=1, out_err=1, out_r=0; the next op proceeds normally.
  - Tag wrap: 17 ops give tags 0..15, then 0.
- Reset mid-WAIT: rst_n low for 2 cycles, then a late mul_valid_out arrives → all outputs 0, busy=0, FIFO empty, no output produced.
